// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: serial rx -> parallel word.
// 16x oversampling, each bit decided by a 3-sample majority vote taken at
// oversample counts 7, 8 and 9. Configurable data width, parity and stop bits.
// Reports parity, framing and overrun errors. Delivers words to a host or FIFO
// over a valid/ready handshake.
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line rate in bit/s; OS_DIV = CLK_FREQ/(BAUD_RATE*16) must be >= 2
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active low
//   rx          serial line, asynchronous, idle high
//   data        received word, LSB received first
//   valid       data and flags are held stable while valid is high
//   ready       consumer accepts the word on a cycle with valid && ready
//   parity_err  parity mismatch for the word in data (qualified by valid)
//   frame_err   a stop bit was sampled low for the word in data (qualified by valid)
//   overrun     one-cycle pulse: a frame completed while valid && !ready, frame dropped
//   busy        receiver is not idle
//   break_det   (only with UART_RX_BREAK_EN) one-cycle pulse on a break frame
//
// Optional feature macro: UART_RX_BREAK_EN
//   Defined: an all-zero frame with a low stop bit is reported on break_det
//   instead of being delivered as a word. Undefined: such a frame is delivered
//   as data 0 with frame_err set.
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_BREAK_EN
    ,
    output logic                 break_det
`endif
);

    localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int BW     = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;

    state_t state, next_state;

    logic                 rx_meta, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp7, samp8, samp9;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 stop_idx;

    logic tick, bit_end, mid_tick, last_stop, complete;
    logic maj_held, maj_live, frame_perr, frame_ferr, is_break;

    // Two-flop synchroniser; resets to the idle-high line level so that
    // reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Decode of the current state and bit timing.
    // maj_live folds in the sample being taken right now (os_cnt 9) so that
    // a stop bit can be judged on the same tick it is completed.
    always_comb begin
        busy       = (state != S_IDLE);
        tick       = busy && (tick_cnt == TICK_LAST);
        bit_end    = tick && (os_cnt == 4'd15);
        mid_tick   = tick && (os_cnt == 4'd9);
        last_stop  = (stop_idx == STOP_LAST);
        complete   = (state == S_STOP) && mid_tick && last_stop;
        maj_held   = (samp7 & samp8) | (samp7 & samp9) | (samp8 & samp9);
        maj_live   = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
        frame_ferr = ferr_acc | ~maj_live;
        frame_perr = (PARITY != 0) && (((^shreg) ^ par_bit) != (PARITY == 2));
`ifdef UART_RX_BREAK_EN
        is_break   = complete && frame_ferr && (shreg == '0) && ((PARITY == 0) || !par_bit);
`else
        is_break   = 1'b0;
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (!rx_s) next_state = S_START;
            S_START:   if (bit_end) next_state = maj_held ? S_IDLE : S_DATA;
            S_DATA:    if (bit_end && (bit_cnt == BIT_LAST))
                           next_state = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:  if (bit_end) next_state = S_STOP;
            S_STOP:    if (complete) next_state = frame_ferr ? S_WAIT_HI : S_IDLE;
            S_WAIT_HI: if (rx_s) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Bit timing and frame assembly. Everything is held cleared while idle,
    // so leaving IDLE always starts the tick and oversample counters at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            samp7    <= 1'b1;
            samp8    <= 1'b1;
            samp9    <= 1'b1;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
            stop_idx <= 1'b0;
        end else if (state == S_IDLE) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                os_cnt <= os_cnt + 4'd1;
                case (os_cnt)
                    4'd7:    samp7 <= rx_s;
                    4'd8:    samp8 <= rx_s;
                    4'd9:    samp9 <= rx_s;
                    default: ;
                endcase
            end
            if (bit_end && (state == S_DATA)) begin
                shreg   <= {maj_held, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (bit_end && (state == S_PARITY)) par_bit <= maj_held;
            if (mid_tick && (state == S_STOP) && !maj_live) ferr_acc <= 1'b1;
            if (bit_end && (state == S_STOP)) stop_idx <= 1'b1;
        end
    end

    // Host handshake. A completed frame loads only if the output slot is
    // empty or being emptied this cycle; otherwise it is dropped and the
    // pending word stays untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_det  <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_det <= is_break;
`endif
            if (complete && !is_break) begin
                if (!valid || ready) begin
                    data       <= shreg;
                    parity_err <= frame_perr;
                    frame_err  <= frame_ferr;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_param
// Bench for uart_rx_param. Three receivers share clock and reset:
//   dut 0: 8 data bits, no parity, 1 stop bit
//   dut 1: 7 data bits, even parity, 2 stop bits
//   dut 2: 9 data bits, odd parity, 1 stop bit
// All use OS_DIV = 4 (64 clocks per bit). A monitor records every accepted
// word; expected words come from a frame-level model of the line format.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int OS   = 4;
    localparam int BITC = 16 * OS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx, ready;
    logic [2:0] valid, perr, ferr, ovr, busy;
    logic [7:0] data0;
    logic [6:0] data1;
    logic [8:0] data2;
`ifdef UART_RX_BREAK_EN
    logic [2:0] brk;
`endif

    int nb [3] = '{8, 7, 9};
    int pm [3] = '{0, 1, 2};
    int ns [3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(64), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data(data0), .valid(valid[0]), .ready(ready[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
`ifdef UART_RX_BREAK_EN
        , .break_det(brk[0])
`endif
    );
    uart_rx_param #(.CLK_FREQ(64), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data(data1), .valid(valid[1]), .ready(ready[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
`ifdef UART_RX_BREAK_EN
        , .break_det(brk[1])
`endif
    );
    uart_rx_param #(.CLK_FREQ(64), .BAUD_RATE(1), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rx[2]), .data(data2), .valid(valid[2]), .ready(ready[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2])
`ifdef UART_RX_BREAK_EN
        , .break_det(brk[2])
`endif
    );

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } word_t;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         d;
        logic [8:0] w;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    word_t wq[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    ovr_cnt [3];
    int    brk_cnt [3];
    bit    valid_seen [3];

    function automatic logic [8:0] dout(input int d);
        case (d)
            0:       return {1'b0, data0};
            1:       return {2'b00, data1};
            default: return data2;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs accepted words and counts pulses.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i]) valid_seen[i] = 1'b1;
            if (valid[i] && ready[i])
                wq.push_back('{d: i, data: dout(i), perr: perr[i], ferr: ferr[i], cyc: cyc});
            if (ovr[i]) ovr_cnt[i]++;
`ifdef UART_RX_BREAK_EN
            if (brk[i]) brk_cnt[i]++;
`endif
        end
    end

    // Frame-level reference: what a correct receiver must report for a frame.
    function automatic exp_t model(input int d, input logic [8:0] w, input logic pbit,
                                   input logic [1:0] stops);
        exp_t m;
        int   ones = 0;
        for (int i = 0; i < nb[d]; i++) ones += int'(w[i]);
        m.data = w & 9'((1 << nb[d]) - 1);
        m.perr = (pm[d] != 0) && (pbit != ((pm[d] == 1) ? ones[0] : !ones[0]));
        m.ferr = !stops[0] || ((ns[d] == 2) && !stops[1]);
        return m;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input int d, input logic v);
        rx[d] = v;
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        rx[d] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, data (LSB first), optional parity and stop bits.
    // stops[0] is the first stop bit; the line is left at the last stop value.
    task automatic send_frame(input int d, input logic [8:0] w, input logic pbit,
                              input logic [1:0] stops, output int t_last);
        @(posedge clk); #1;
        drive_bit(d, 1'b0);
        for (int i = 0; i < nb[d]; i++) drive_bit(d, w[i]);
        if (pm[d] != 0) drive_bit(d, pbit);
        if (ns[d] == 2) drive_bit(d, stops[0]);
        t_last = cyc;
        drive_bit(d, (ns[d] == 2) ? stops[1] : stops[0]);
    endtask

    task automatic expect_word(input int d, input exp_t e, input int t_last, input bit timed);
        word_t w;
        int    lat;
        if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL word_present dut%0d: got no word expected data 0x%0h", d, e.data);
        end else begin
            w = wq.pop_front();
            check_output($sformatf("dut%0d_source", d), w.d, d);
            check_output($sformatf("dut%0d_data", d), {23'd0, w.data}, {23'd0, e.data});
            check_output($sformatf("dut%0d_parity_err", d), {31'd0, w.perr}, {31'd0, e.perr});
            check_output($sformatf("dut%0d_frame_err", d), {31'd0, w.ferr}, {31'd0, e.ferr});
            if (timed) begin
                lat = w.cyc - t_last;
                checks++;
                if (lat < 10 * OS - 1 || lat > 10 * OS + 6) begin
                    errors++;
                    $display("[TB] FAIL dut%0d_latency: got %0d cycles expected about %0d", d, lat, 10 * OS + 3);
                end
            end
        end
        check_output($sformatf("dut%0d_extra_words", d), wq.size(), 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        int   t;
        exp_t e;
        send_frame(v.d, v.w, v.pbit, v.stops, t);
        idle(v.d, BITC);
        e.data = v.exp_data;
        e.perr = v.exp_perr;
        e.ferr = v.exp_ferr;
        expect_word(v.d, e, t, 1'b1);
    endtask

    initial begin
        vec_t       vecs [9];
        exp_t       e;
        int         t;
        int         d;
        logic [8:0] w;
        logic [1:0] stops;
        logic       pbit, good;
        int         ones;

        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h035, 1'b0, 2'b11, 9'h035, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h035, 1'b1, 2'b11, 9'h035, 1'b1, 1'b0};
        vecs[3] = '{1, 9'h05A, 1'b0, 2'b01, 9'h05A, 1'b0, 1'b1};
        vecs[4] = '{1, 9'h001, 1'b1, 2'b10, 9'h001, 1'b0, 1'b1};
        vecs[5] = '{2, 9'h1FF, 1'b0, 2'b11, 9'h1FF, 1'b0, 1'b0};
        vecs[6] = '{2, 9'h100, 1'b1, 2'b11, 9'h100, 1'b1, 1'b0};
        vecs[7] = '{2, 9'h000, 1'b1, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[8] = '{0, 9'h080, 1'b0, 2'b10, 9'h080, 1'b0, 1'b1};

        rst_n = 1'b0;
        rx    = 3'b111;
        ready = 3'b111;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("reset_data%0d", i), {23'd0, dout(i)}, 0);
            check_output($sformatf("reset_valid%0d", i), {31'd0, valid[i]}, 0);
            check_output($sformatf("reset_perr%0d", i), {31'd0, perr[i]}, 0);
            check_output($sformatf("reset_ferr%0d", i), {31'd0, ferr[i]}, 0);
            check_output($sformatf("reset_overrun%0d", i), {31'd0, ovr[i]}, 0);
            check_output($sformatf("reset_busy%0d", i), {31'd0, busy[i]}, 0);
        end
        rst_n = 1'b1;
        idle(0, 8);

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

        // Second stop bit low and held low: receiver parks until the line rises.
        send_frame(1, 9'h05A, 1'b0, 2'b01, t);
        rx[1] = 1'b0;
        repeat (BITC) @(posedge clk);
        #1;
        check_output("wait_hi_busy", {31'd0, busy[1]}, 1);
        e = '{data: 9'h05A, perr: 1'b0, ferr: 1'b1};
        expect_word(1, e, t, 1'b1);
        idle(1, 6);
        check_output("wait_hi_release", {31'd0, busy[1]}, 0);
        idle(1, BITC);
        check_output("wait_hi_no_retrigger", wq.size(), 0);

        // Overrun: host stalls across two frames.
        ready[0] = 1'b0;
        ovr_cnt[0] = 0;
        send_frame(0, 9'h011, 1'b0, 2'b11, t);
        idle(0, BITC);
        send_frame(0, 9'h022, 1'b0, 2'b11, t);
        idle(0, BITC);
        check_output("overrun_valid_held", {31'd0, valid[0]}, 1);
        check_output("overrun_data_kept", {24'd0, data0}, 32'h11);
        check_output("overrun_pulses", ovr_cnt[0], 1);
        ready[0] = 1'b1;
        @(posedge clk); #1;
        check_output("overrun_valid_drop", {31'd0, valid[0]}, 0);
        e = '{data: 9'h011, perr: 1'b0, ferr: 1'b0};
        expect_word(0, e, 0, 1'b0);

        // False start: 4*OS_DIV clocks of low line.
        valid_seen[0] = 1'b0;
        rx[0] = 1'b0;
        repeat (4 * OS) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_output("false_start_busy", {31'd0, busy[0]}, 1);
        repeat (16 * OS + 8) @(posedge clk);
        #1;
        check_output("false_start_idle", {31'd0, busy[0]}, 0);
        check_output("false_start_no_valid", {31'd0, valid_seen[0]}, 0);

        // Reset in the middle of a frame, with a word pending.
        ready[0] = 1'b0;
        send_frame(0, 9'h077, 1'b0, 2'b11, t);
        idle(0, BITC);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rx[0] = 1'b1;
        repeat (BITC / 2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_valid", {31'd0, valid[0]}, 0);
        check_output("midreset_data", {24'd0, data0}, 0);
        check_output("midreset_busy", {31'd0, busy[0]}, 0);
        ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, BITC);
        check_output("midreset_no_word", wq.size(), 0);
        send_frame(0, 9'h03C, 1'b0, 2'b11, t);
        idle(0, BITC);
        e = '{data: 9'h03C, perr: 1'b0, ferr: 1'b0};
        expect_word(0, e, t, 1'b1);

        // Line held low for 12 bit times.
        valid_seen[0] = 1'b0;
        brk_cnt[0] = 0;
        @(posedge clk); #1;
        rx[0] = 1'b0;
        repeat (12 * BITC) @(posedge clk);
        #1;
        idle(0, BITC);
`ifdef UART_RX_BREAK_EN
        check_output("break_pulses", brk_cnt[0], 1);
        check_output("break_no_valid", {31'd0, valid_seen[0]}, 0);
        check_output("break_no_word", wq.size(), 0);
`else
        e = '{data: 9'h000, perr: 1'b0, ferr: 1'b1};
        expect_word(0, e, 0, 1'b0);
`endif

        // Randomised frames on all three receivers.
        for (int r = 0; r < 30; r++) begin
            d     = r % 3;
            w     = 9'($urandom);
            stops = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            ones  = 0;
            for (int i = 0; i < nb[d]; i++) ones += int'(w[i]);
            good  = (pm[d] == 1) ? ones[0] : !ones[0];
            pbit  = ($urandom_range(0, 3) == 0) ? !good : good;
            e     = model(d, w, pbit, stops);
            if (e.ferr && (e.data == 9'd0) && ((pm[d] == 0) || !pbit)) begin
                w[0] = 1'b1;
                e    = model(d, w, pbit, stops);
            end
            send_frame(d, w, pbit, stops, t);
            idle(d, BITC);
            expect_word(d, e, t, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
